// File: rtl/vregfile_gen.sv
// Parametrised scalar + vector register file with vl-masked vector writes and a vector-bank clear engine.
// Defining VREGFILE_BYPASS_EN enables write-first forwarding on address collisions.
module vregfile_gen #(
    parameter int DW        = 32,
    parameter int NUM_SREGS = 8,
    parameter int SAW       = 3,
    parameter int NUM_VREGS = 4,
    parameter int VAW       = 2,
    parameter int LANES     = 8,
    parameter int VL_IDX    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SAW-1:0]        s_raddr1,
    output logic [DW-1:0]         s_rdata1,
    input  logic [SAW-1:0]        s_raddr2,
    output logic [DW-1:0]         s_rdata2,
    input  logic                  s_we,
    input  logic [SAW-1:0]        s_waddr,
    input  logic [DW-1:0]         s_wdata,
    input  logic [VAW-1:0]        v_raddr1,
    output logic [LANES*DW-1:0]   v_rdata1,
    input  logic [VAW-1:0]        v_raddr2,
    output logic [LANES*DW-1:0]   v_rdata2,
    input  logic                  v_we,
    input  logic [VAW-1:0]        v_waddr,
    input  logic [LANES*DW-1:0]   v_wdata,
    output logic [DW-1:0]         vl,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_done
);
    // state | meaning
    // IDLE  | vector writes accepted, waiting for clr_req
    // CLEAR | zeroing vreg[clr_ptr] one register per cycle, busy high

    localparam int VW = LANES * DW;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                          state_q, state_d;
    logic [VAW-1:0]                  clr_ptr_q, clr_ptr_d;
    logic                            busy_d, clr_done_d;

    logic [NUM_SREGS-1:0][DW-1:0]    sreg;
    logic [NUM_VREGS-1:0][VW-1:0]    vreg;

    logic [LANES-1:0]                lane_en;
    logic                            s_wr_ok, v_wr_ok, clr_act;

    logic [SAW-1:0]                  s_raddr [2];
    logic [DW-1:0]                   s_rd    [2];
    logic [VAW-1:0]                  v_raddr [2];
    logic [VW-1:0]                   v_rd    [2];

    function automatic logic saddr_ok(input logic [SAW-1:0] a);
        return ({1'b0, a} < (SAW+1)'(NUM_SREGS));
    endfunction

    function automatic logic vaddr_ok(input logic [VAW-1:0] a);
        return ({1'b0, a} < (VAW+1)'(NUM_VREGS));
    endfunction

    // sreg[0] is never written, so a VL_IDX of 0 would read as vl = 0
    assign vl = sreg[VL_IDX];

    always_comb begin
        lane_en = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_en[i] = (sreg[VL_IDX] > DW'(i));
        end
    end

    assign clr_act = (state_q == CLEAR);
    assign s_wr_ok = s_we && (s_waddr != '0) && saddr_ok(s_waddr);
    assign v_wr_ok = v_we && (state_q == IDLE) && vaddr_ok(v_waddr);

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        busy_d     = 1'b0;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                    busy_d    = 1'b1;
                end
            end
            CLEAR: begin
                busy_d    = 1'b1;
                clr_ptr_d = clr_ptr_q + VAW'(1);
                if (clr_ptr_q == VAW'(NUM_VREGS - 1)) begin
                    state_d    = IDLE;
                    clr_ptr_d  = '0;
                    busy_d     = 1'b0;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
            busy      <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy      <= busy_d;
            clr_done  <= clr_done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
        end else if (s_wr_ok) begin
            sreg[s_waddr] <= s_wdata;
        end
    end

    // Clear and accepted writes are mutually exclusive: writes need IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vreg <= '0;
        end else if (clr_act) begin
            vreg[clr_ptr_q] <= '0;
        end else if (v_wr_ok) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_en[i]) begin
                    vreg[v_waddr][i*DW +: DW] <= v_wdata[i*DW +: DW];
                end
            end
        end
    end

    assign s_raddr[0] = s_raddr1;
    assign s_raddr[1] = s_raddr2;
    assign v_raddr[0] = v_raddr1;
    assign v_raddr[1] = v_raddr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            s_rd[p] = '0;
            if ((s_raddr[p] != '0) && saddr_ok(s_raddr[p])) begin
                s_rd[p] = sreg[s_raddr[p]];
            end
`ifdef VREGFILE_BYPASS_EN
            if (s_wr_ok && (s_waddr == s_raddr[p])) begin
                s_rd[p] = s_wdata;
            end
`endif
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            v_rd[p] = '0;
            if (vaddr_ok(v_raddr[p])) begin
                v_rd[p] = vreg[v_raddr[p]];
            end
`ifdef VREGFILE_BYPASS_EN
            if (clr_act && (v_raddr[p] == clr_ptr_q)) begin
                v_rd[p] = '0;
            end else if (v_wr_ok && (v_raddr[p] == v_waddr)) begin
                for (int i = 0; i < LANES; i++) begin
                    if (lane_en[i]) begin
                        v_rd[p][i*DW +: DW] = v_wdata[i*DW +: DW];
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rdata1 <= '0;
            s_rdata2 <= '0;
            v_rdata1 <= '0;
            v_rdata2 <= '0;
        end else begin
            s_rdata1 <= s_rd[0];
            s_rdata2 <= s_rd[1];
            v_rdata1 <= v_rd[0];
            v_rdata2 <= v_rd[1];
        end
    end

endmodule

// File: tb/tb_vregfile_gen.sv
// Bench for vregfile_gen: scoreboard of expected read/vl/busy values plus directed scenario checks.
module tb_vregfile_gen;
    localparam int DW = 32;
    localparam int LANES = 8;
    localparam int VW = DW * LANES;

    logic           clk = 1'b0;
    logic           rst;
    logic [2:0]     s_raddr1, s_raddr2, s_waddr;
    logic [DW-1:0]  s_rdata1, s_rdata2, s_wdata;
    logic           s_we;
    logic [1:0]     v_raddr1, v_raddr2, v_waddr;
    logic [VW-1:0]  v_rdata1, v_rdata2, v_wdata;
    logic           v_we;
    logic [DW-1:0]  vl;
    logic           clr_req, busy, clr_done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vregfile_gen dut (
        .clk(clk), .rst(rst),
        .s_raddr1(s_raddr1), .s_rdata1(s_rdata1),
        .s_raddr2(s_raddr2), .s_rdata2(s_rdata2),
        .s_we(s_we), .s_waddr(s_waddr), .s_wdata(s_wdata),
        .v_raddr1(v_raddr1), .v_rdata1(v_rdata1),
        .v_raddr2(v_raddr2), .v_rdata2(v_rdata2),
        .v_we(v_we), .v_waddr(v_waddr), .v_wdata(v_wdata),
        .vl(vl), .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
    );

    typedef struct {
        logic [DW-1:0] s1, s2;
        logic [VW-1:0] v1, v2;
        logic [DW-1:0] vlv;
        logic          bsy, dn;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    logic [DW-1:0] sm [8];
    logic [VW-1:0] vm [4];
    bit            m_busy, m_done;
    int            m_ptr;

    task automatic model_reset();
        foreach (sm[i]) sm[i] = '0;
        foreach (vm[i]) vm[i] = '0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_ptr = 0;
        sb.delete();
    endtask

    function automatic int eff_vl();
        return (sm[7] > 32'd8) ? 8 : int'(sm[7]);
    endfunction

    function automatic logic [DW-1:0] exp_s(input logic [2:0] a);
        logic [DW-1:0] r;
        r = (a == 3'd0) ? '0 : sm[a];
`ifdef VREGFILE_BYPASS_EN
        if (s_we && s_waddr == a && a != 3'd0) r = s_wdata;
`endif
        return r;
    endfunction

    function automatic logic [VW-1:0] exp_v(input logic [1:0] a);
        logic [VW-1:0] r;
        r = vm[a];
`ifdef VREGFILE_BYPASS_EN
        if (m_busy && int'(a) == m_ptr) r = '0;
        else if (v_we && !m_busy && a == v_waddr)
            for (int i = 0; i < eff_vl(); i++) r[i*DW +: DW] = v_wdata[i*DW +: DW];
`endif
        return r;
    endfunction

    // One clock: compute expected outputs from the pre-edge model, advance the model, push.
    task automatic step();
        exp_t e;
        int ev;
        ev = eff_vl();
        e.s1 = exp_s(s_raddr1);
        e.s2 = exp_s(s_raddr2);
        e.v1 = exp_v(v_raddr1);
        e.v2 = exp_v(v_raddr2);
        if (m_busy) begin
            vm[m_ptr] = '0;
            if (m_ptr == 3) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_ptr = 0;
            end else begin
                m_ptr++;
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (v_we)
                for (int i = 0; i < ev; i++) vm[v_waddr][i*DW +: DW] = v_wdata[i*DW +: DW];
            if (clr_req) begin
                m_busy = 1'b1;
                m_ptr = 0;
            end
        end
        if (s_we && s_waddr != 3'd0) sm[s_waddr] = s_wdata;
        e.vlv = sm[7];
        e.bsy = m_busy;
        e.dn = m_done;
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            me = sb.pop_front();
            total++;
            if (s_rdata1 !== me.s1) begin bad++; $display("FAIL sb_s_rdata1 got=%h exp=%h", s_rdata1, me.s1); end
            total++;
            if (s_rdata2 !== me.s2) begin bad++; $display("FAIL sb_s_rdata2 got=%h exp=%h", s_rdata2, me.s2); end
            total++;
            if (v_rdata1 !== me.v1) begin bad++; $display("FAIL sb_v_rdata1 got=%h exp=%h", v_rdata1, me.v1); end
            total++;
            if (v_rdata2 !== me.v2) begin bad++; $display("FAIL sb_v_rdata2 got=%h exp=%h", v_rdata2, me.v2); end
            total++;
            if (vl !== me.vlv) begin bad++; $display("FAIL sb_vl got=%h exp=%h", vl, me.vlv); end
            total++;
            if (busy !== me.bsy) begin bad++; $display("FAIL sb_busy got=%b exp=%b", busy, me.bsy); end
            total++;
            if (clr_done !== me.dn) begin bad++; $display("FAIL sb_clr_done got=%b exp=%b", clr_done, me.dn); end
        end
    end

    task automatic idle();
        s_we = 1'b0;
        v_we = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic set_vl(input logic [DW-1:0] v);
        s_we = 1'b1; s_waddr = 3'd7; s_wdata = v;
        step();
        s_we = 1'b0;
    endtask

    task automatic vwrite(input logic [1:0] a, input logic [VW-1:0] d);
        v_we = 1'b1; v_waddr = a; v_wdata = d;
        step();
        v_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        s_raddr1 = '0; s_raddr2 = '0; s_waddr = '0; s_wdata = '0;
        v_raddr1 = '0; v_raddr2 = '0; v_waddr = '0; v_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (s_rdata1 !== '0 || v_rdata1 !== '0) begin
            bad++; $display("FAIL por_rdata got=%h/%h exp=0", s_rdata1, v_rdata1);
        end
        total++;
        if (busy !== 1'b0 || clr_done !== 1'b0) begin
            bad++; $display("FAIL por_busy got=%b%b exp=00", busy, clr_done);
        end
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            s_raddr1 = a[2:0]; s_raddr2 = 3'(7 - a); v_raddr1 = a[1:0]; v_raddr2 = a[2:1];
            step();
            total++;
            if (s_rdata1 !== '0 || v_rdata1 !== '0) begin
                bad++; $display("FAIL por_read%0d got=%h/%h exp=0", a, s_rdata1, v_rdata1);
            end
        end
    endtask

    task automatic test_scalar();
        s_raddr1 = 3'd0; s_raddr2 = 3'd0;
        s_we = 1'b1; s_waddr = 3'd3; s_wdata = 32'hDEADBEEF;
        step();
        idle();
        s_raddr1 = 3'd3; s_raddr2 = 3'd3;
        step();
        total++;
        if (s_rdata1 !== 32'hDEADBEEF || s_rdata2 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL scalar_rd got=%h/%h exp=deadbeef", s_rdata1, s_rdata2);
        end
        s_raddr1 = 3'd0;
        s_we = 1'b1; s_waddr = 3'd0; s_wdata = 32'h5;
        step();
        idle();
        step();
        total++;
        if (s_rdata1 !== 32'h0) begin
            bad++; $display("FAIL scalar_r0 got=%h exp=0", s_rdata1);
        end
    endtask

    task automatic test_vl_mask();
        logic [VW-1:0] ev;
        v_raddr1 = 2'd1;
        set_vl(32'd8);
        vwrite(2'd1, {8{32'h11111111}});
        set_vl(32'd3);
        vwrite(2'd1, {8{32'hAAAAAAAA}});
        step();
        ev = {{5{32'h11111111}}, {3{32'hAAAAAAAA}}};
        total++;
        if (v_rdata1 !== ev) begin bad++; $display("FAIL vl3_mask got=%h exp=%h", v_rdata1, ev); end
        set_vl(32'd20);
        vwrite(2'd1, {8{32'h22222222}});
        step();
        ev = {8{32'h22222222}};
        total++;
        if (v_rdata1 !== ev) begin bad++; $display("FAIL vl20_mask got=%h exp=%h", v_rdata1, ev); end
        set_vl(32'd0);
        vwrite(2'd1, {8{32'h33333333}});
        step();
        total++;
        if (v_rdata1 !== ev || vl !== 32'd0) begin
            bad++; $display("FAIL vl0_mask got=%h vl=%h exp=%h vl=0", v_rdata1, vl, ev);
        end
    endtask

    task automatic test_same_cycle_vl();
        logic [VW-1:0] ev;
        set_vl(32'd8);
        vwrite(2'd2, {8{32'h44444444}});
        set_vl(32'd2);
        s_we = 1'b1; s_waddr = 3'd7; s_wdata = 32'd8;
        v_we = 1'b1; v_waddr = 2'd2; v_wdata = {8{32'h55555555}};
        step();
        idle();
        v_raddr1 = 2'd2;
        step();
        ev = {{6{32'h44444444}}, {2{32'h55555555}}};
        total++;
        if (v_rdata1 !== ev) begin bad++; $display("FAIL same_cycle_vl got=%h exp=%h", v_rdata1, ev); end
        total++;
        if (vl !== 32'd8) begin bad++; $display("FAIL same_cycle_newvl got=%h exp=8", vl); end
    endtask

    task automatic test_clear();
        logic [DW-1:0] w;
        logic eb, ed;
        set_vl(32'd8);
        for (int a = 0; a < 4; a++) begin
            w = 32'h01010101 * (a + 1);
            vwrite(a[1:0], {8{w}});
        end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        total++;
        if (busy !== 1'b1 || clr_done !== 1'b0) begin
            bad++; $display("FAIL clr_start got=%b%b exp=10", busy, clr_done);
        end
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin v_we = 1'b1; v_waddr = 2'd0; v_wdata = {8{32'h77777777}}; end
            if (c == 3) clr_req = 1'b1;
            step();
            idle();
            eb = (c < 4);
            ed = (c == 4);
            total++;
            if (busy !== eb || clr_done !== ed) begin
                bad++; $display("FAIL clr_cyc%0d got=%b%b exp=%b%b", c, busy, clr_done, eb, ed);
            end
        end
        for (int a = 0; a < 4; a++) begin
            v_raddr1 = a[1:0];
            step();
            total++;
            if (v_rdata1 !== '0) begin bad++; $display("FAIL clr_vreg%0d got=%h exp=0", a, v_rdata1); end
        end
    endtask

    task automatic test_clear_abort();
        vwrite(2'd3, {8{32'h99999999}});
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (busy !== 1'b0 || clr_done !== 1'b0 || s_rdata1 !== '0 || v_rdata1 !== '0) begin
            bad++; $display("FAIL abort_rst got=%b%b %h %h exp=00 0 0", busy, clr_done, s_rdata1, v_rdata1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            total++;
            if (busy !== 1'b0 || clr_done !== 1'b0) begin
                bad++; $display("FAIL abort_cyc%0d got=%b%b exp=00", c, busy, clr_done);
            end
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] es;
        logic [VW-1:0] ev;
        s_raddr1 = 3'd0;
        s_we = 1'b1; s_waddr = 3'd2; s_wdata = 32'h1111;
        step();
        s_wdata = 32'h1234; s_raddr1 = 3'd2;
        step();
        idle();
`ifdef VREGFILE_BYPASS_EN
        es = 32'h1234;
`else
        es = 32'h1111;
`endif
        total++;
        if (s_rdata1 !== es) begin bad++; $display("FAIL byp_scalar got=%h exp=%h", s_rdata1, es); end
        step();
        total++;
        if (s_rdata1 !== 32'h1234) begin bad++; $display("FAIL byp_scalar_after got=%h exp=1234", s_rdata1); end
        set_vl(32'd8);
        vwrite(2'd3, {8{32'h66666666}});
        set_vl(32'd4);
        v_raddr2 = 2'd3;
        vwrite(2'd3, {8{32'h88888888}});
`ifdef VREGFILE_BYPASS_EN
        ev = {{4{32'h66666666}}, {4{32'h88888888}}};
`else
        ev = {8{32'h66666666}};
`endif
        total++;
        if (v_rdata2 !== ev) begin bad++; $display("FAIL byp_vector got=%h exp=%h", v_rdata2, ev); end
        step();
        ev = {{4{32'h66666666}}, {4{32'h88888888}}};
        total++;
        if (v_rdata2 !== ev) begin bad++; $display("FAIL byp_vector_after got=%h exp=%h", v_rdata2, ev); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            s_we = 1'($urandom_range(0, 1));
            s_waddr = 3'($urandom_range(0, 7));
            s_wdata = (s_waddr == 3'd7) ? 32'($urandom_range(0, 11)) : $urandom;
            s_raddr1 = 3'($urandom_range(0, 7));
            s_raddr2 = 3'($urandom_range(0, 7));
            v_we = 1'($urandom_range(0, 1));
            v_waddr = 2'($urandom_range(0, 3));
            v_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            v_raddr1 = 2'($urandom_range(0, 3));
            v_raddr2 = 2'($urandom_range(0, 3));
            clr_req = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        set_vl(32'd8);
        vwrite(2'd1, {8{32'hCAFEF00D}});
        s_we = 1'b1; s_waddr = 3'd5; s_wdata = 32'hABCD;
        clr_req = 1'b1;
        step();
        idle();
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (s_rdata1 !== '0 || s_rdata2 !== '0 || v_rdata1 !== '0 || v_rdata2 !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_rst got=%h %h %h %h %b exp=0", s_rdata1, s_rdata2, v_rdata1, v_rdata2, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            s_raddr1 = a[2:0]; s_raddr2 = a[2:0]; v_raddr1 = a[1:0]; v_raddr2 = a[1:0];
            step();
            total++;
            if (s_rdata1 !== '0 || v_rdata1 !== '0 || vl !== '0) begin
                bad++; $display("FAIL mid_read%0d got=%h/%h/%h exp=0", a, s_rdata1, v_rdata1, vl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_vl_mask();
        test_same_cycle_vl();
        test_clear();
        test_clear_abort();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
